fifo_push_arbiter: RTL and testbench

- Shares the push port of one D_WIDTH-wide, DEPTH-entry FIFO between N_REQ producers.
- Grants producers round-robin and registers the winner's word onto push/up_data.
- Tracks FIFO occupancy from its own push and the consumer's pop, and stops granting before the FIFO overflows.
- Sits directly in front of the FIFO; pop comes from the downstream consumer and is only observed here.

---
 rtl/fifo_push_arbiter_pkg.sv | 20 ++
 rtl/fifo_push_arbiter_if.sv | 37 +++
 rtl/fifo_push_arbiter_rr_picker.sv | 27 ++
 rtl/fifo_push_arbiter.sv | 108 ++++++++++
 tb/tb_fifo_push_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_push_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_push_arb_pkg
// Brief    : Shared constants and helpers for the FIFO push arbiter.
// Revision : 1.0
// ============================================================================
package fifo_push_arb_pkg;

    localparam int STAT_W = 16;

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_push_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_push_arbiter_if
// Brief    : Producer request bus, FIFO push side and occupancy status.
// Revision : 1.0
// ============================================================================
interface fifo_push_arbiter_if
    import fifo_push_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int D_WIDTH = 6,
    parameter int DEPTH   = 8
);
    localparam int c_cnt_w = cnt_w(DEPTH);

    logic [N_REQ-1:0]         req;
    logic [N_REQ*D_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]         gnt;
    logic                     push;
    logic [D_WIDTH-1:0]       up_data;
    logic                     pop;
    logic [c_cnt_w-1:0]       count;
    logic                     full;
    logic                     empty;

    modport master (
        input  req, req_data, pop,
        output gnt, push, up_data, count, full, empty
    );

    modport slave (
        output req, req_data, pop,
        input  gnt, push, up_data, count, full, empty
    );

endinterface
`default_nettype wire

// File: rtl/fifo_push_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational round-robin pick: first set req at or after ptr.
// Revision : 1.0
// ============================================================================
module rr_picker #(
    parameter int N = 4
) (
    input  wire logic [N-1:0]         req,
    input  wire logic [$clog2(N)-1:0] ptr,
    input  wire logic                 en,
    output logic      [N-1:0]         gnt
);

    logic [N-1:0] w_rot;
    logic [N-1:0] w_pick;
    logic [N-1:0] w_back;

    // Rotate so ptr lands at bit 0, isolate lowest set bit, rotate back.
    assign w_rot  = N'({req, req} >> ptr);
    assign w_pick = w_rot & (~w_rot + N'(1));
    assign w_back = N'({w_pick, w_pick} >> (N - int'(ptr)));
    assign gnt    = en ? w_back : '0;

endmodule
`default_nettype wire

// File: rtl/fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_push_arbiter
// Brief    : Round-robin arbiter sharing one FIFO push port, with occupancy
//            tracking. Optional per-producer grant counters when
//            FIFO_PUSH_ARB_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
module fifo_push_arbiter
    import fifo_push_arb_pkg::*;
#(
    parameter int D_WIDTH = 6,
    parameter int N_REQ   = 4,
    parameter int DEPTH   = 8
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    fifo_push_arbiter_if.master        bus
`ifdef FIFO_PUSH_ARB_STATS_EN
    ,
    input  wire logic                  stats_clr,
    output logic [N_REQ*STAT_W-1:0]    grant_cnt
`endif
);

    localparam int               c_cnt_w = cnt_w(DEPTH);
    localparam int               c_ptr_w = $clog2(N_REQ);
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(DEPTH);

    logic [c_ptr_w-1:0] r_rr_ptr;
    logic               r_push;
    logic [D_WIDTH-1:0] r_up_data;
    logic [c_cnt_w-1:0] r_count;

    logic               w_en;
    logic [N_REQ-1:0]   w_gnt;
    logic [c_ptr_w-1:0] w_idx;
    logic [D_WIDTH-1:0] w_word;
    logic               w_pop_ok;

    // In-flight push is counted; a same-cycle pop is deliberately not credited.
    assign w_en = !rst && (({1'b0, r_count} + (c_cnt_w + 1)'(r_push)) < c_depth);

    rr_picker #(.N(N_REQ)) u_picker (
        .req (bus.req),
        .ptr (r_rr_ptr),
        .en  (w_en),
        .gnt (w_gnt)
    );

    always_comb begin
        w_idx  = '0;
        w_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt[i]) begin
                w_idx  = c_ptr_w'(i);
                w_word = bus.req_data[i*D_WIDTH +: D_WIDTH];
            end
        end
    end

    assign w_pop_ok = bus.pop && (r_count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_push    <= 1'b0;
            r_up_data <= '0;
            r_count   <= '0;
        end else begin
            r_push  <= |w_gnt;
            r_count <= r_count + c_cnt_w'(r_push) - c_cnt_w'(w_pop_ok);
            if (|w_gnt) begin
                r_up_data <= w_word;
                r_rr_ptr  <= c_ptr_w'(rr_next(int'(w_idx), N_REQ));
            end
        end
    end

    assign bus.gnt     = w_gnt;
    assign bus.push    = r_push;
    assign bus.up_data = r_up_data;
    assign bus.count   = r_count;
    assign bus.full    = (r_count == c_cnt_w'(DEPTH));
    assign bus.empty   = (r_count == '0);

`ifdef FIFO_PUSH_ARB_STATS_EN
    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_stats
            logic [STAT_W-1:0] r_cnt;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (stats_clr) begin
                    r_cnt <= '0;
                end else if (w_gnt[i] && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + STAT_W'(1);
                end
            end

            assign grant_cnt[i*STAT_W +: STAT_W] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_push_arbiter
// Brief    : Directed self-checking bench for fifo_push_arbiter.
// Revision : 1.0
// ============================================================================
module tb_fifo_push_arbiter;

    localparam int N_REQ   = 4;
    localparam int D_WIDTH = 6;
    localparam int DEPTH   = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fifo_push_arbiter_if #(.N_REQ(N_REQ), .D_WIDTH(D_WIDTH), .DEPTH(DEPTH)) bus ();

`ifdef FIFO_PUSH_ARB_STATS_EN
    logic                  stats_clr;
    logic [N_REQ*16-1:0]   grant_cnt;
`endif

    fifo_push_arbiter #(.D_WIDTH(D_WIDTH), .N_REQ(N_REQ), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef FIFO_PUSH_ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic test_reset;
        logic [10:0] obs;
        rst = 1'b1;
        bus.req = '0;
        bus.req_data = '0;
        bus.pop = 1'b0;
`ifdef FIFO_PUSH_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        #1;
        obs = {bus.gnt, bus.push, bus.count, bus.empty, bus.full};
        checks++;
        if (obs !== 11'b0000_0_0000_1_0) begin
            failures++;
            $display("FAIL reset_state: got %b expected %b", obs, 11'b0000_0_0000_1_0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            obs = {bus.gnt, bus.push, bus.count, bus.empty, bus.full};
            checks++;
            if (obs !== 11'b0000_0_0000_1_0) begin
                failures++;
                $display("FAIL idle_%0d: got %b expected %b", c, obs, 11'b0000_0_0000_1_0);
            end
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_g;
        logic [5:0] exp_d;
        @(negedge clk);
        bus.req      = 4'b1111;
        bus.req_data = {6'h13, 6'h12, 6'h11, 6'h10};
        bus.pop      = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (k < 5) begin
                exp_g = 4'b0001 << (k % 4);
                checks++;
                if (bus.gnt !== exp_g) begin
                    failures++;
                    $display("FAIL rr_gnt_%0d: got %b expected %b", k, bus.gnt, exp_g);
                end
            end
            if (k > 0) begin
                exp_d = 6'h10 + 6'((k - 1) % 4);
                checks++;
                if (bus.push !== 1'b1 || bus.up_data !== exp_d) begin
                    failures++;
                    $display("FAIL rr_data_%0d: got push=%b data=%h expected push=1 data=%h",
                             k, bus.push, bus.up_data, exp_d);
                end
            end
            checks++;
            if (bus.count > 1) begin
                failures++;
                $display("FAIL rr_count_%0d: got %0d expected <=1", k, bus.count);
            end
        end
        bus.req = '0;
        repeat (3) @(negedge clk);
        bus.pop = 1'b0;
        #1;
        checks++;
        if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
            failures++;
            $display("FAIL rr_drain: got count=%0d empty=%b expected 0 1", bus.count, bus.empty);
        end
    endtask

    task automatic test_fill_full;
        int grants = 0;
        @(negedge clk);
        bus.req = 4'b0100;
        bus.pop = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus.gnt === 4'b0100) grants++;
            @(negedge clk);
        end
        #1;
        checks++;
        if (grants != 8) begin
            failures++;
            $display("FAIL fill_grants: got %0d expected 8", grants);
        end
        checks++;
        if (bus.count !== 4'd8 || bus.full !== 1'b1 || bus.gnt !== 4'b0000 || bus.push !== 1'b0) begin
            failures++;
            $display("FAIL fill_full: got count=%0d full=%b gnt=%b push=%b expected 8 1 0000 0",
                     bus.count, bus.full, bus.gnt, bus.push);
        end
        bus.pop = 1'b1;
        #1;
        checks++;
        if (bus.gnt !== 4'b0000) begin
            failures++;
            $display("FAIL full_pop_no_gnt: got %b expected 0000", bus.gnt);
        end
        @(negedge clk);
        bus.pop = 1'b0;
        #1;
        checks++;
        if (bus.count !== 4'd7 || bus.gnt !== 4'b0100 || bus.full !== 1'b0) begin
            failures++;
            $display("FAIL after_pop: got count=%0d gnt=%b full=%b expected 7 0100 0",
                     bus.count, bus.gnt, bus.full);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.count !== 4'd7 || bus.push !== 1'b1 || bus.gnt !== 4'b0000) begin
            failures++;
            $display("FAIL refill_push: got count=%0d push=%b gnt=%b expected 7 1 0000",
                     bus.count, bus.push, bus.gnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.count !== 4'd8 || bus.full !== 1'b1) begin
            failures++;
            $display("FAIL refull: got count=%0d full=%b expected 8 1", bus.count, bus.full);
        end
        bus.req = '0;
        bus.pop = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        checks++;
        if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
            failures++;
            $display("FAIL drain_empty: got count=%0d empty=%b expected 0 1", bus.count, bus.empty);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (bus.count !== 4'd0) begin
            failures++;
            $display("FAIL pop_on_empty: got %0d expected 0", bus.count);
        end
        bus.pop = 1'b0;
    endtask

    task automatic test_simul_push_pop;
        @(negedge clk);
        bus.req = 4'b1000;
        bus.pop = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (bus.count !== 4'd3 || bus.push !== 1'b1) begin
            failures++;
            $display("FAIL simul_setup: got count=%0d push=%b expected 3 1", bus.count, bus.push);
        end
        bus.pop = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (bus.count !== 4'd3 || bus.push !== 1'b1) begin
            failures++;
            $display("FAIL simul_hold1: got count=%0d push=%b expected 3 1", bus.count, bus.push);
        end
        bus.req = '0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.count !== 4'd3 || bus.push !== 1'b0) begin
            failures++;
            $display("FAIL simul_hold2: got count=%0d push=%b expected 3 0", bus.count, bus.push);
        end
        repeat (3) @(negedge clk);
        bus.pop = 1'b0;
        #1;
        checks++;
        if (bus.count !== 4'd0) begin
            failures++;
            $display("FAIL simul_drain: got %0d expected 0", bus.count);
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        bus.req      = 4'b0001;
        bus.req_data = {6'h23, 6'h22, 6'h21, 6'h20};
        bus.pop      = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        checks++;
        if (bus.count !== 4'd5 || bus.push !== 1'b1) begin
            failures++;
            $display("FAIL areset_setup: got count=%0d push=%b expected 5 1", bus.count, bus.push);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.push !== 1'b0 || bus.count !== 4'd0 || bus.gnt !== 4'b0000 ||
            bus.up_data !== 6'h00 || bus.empty !== 1'b1) begin
            failures++;
            $display("FAIL areset_clear: got push=%b count=%0d gnt=%b data=%h empty=%b expected 0 0 0000 00 1",
                     bus.push, bus.count, bus.gnt, bus.up_data, bus.empty);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b1001;
        #1;
        checks++;
        if (bus.gnt !== 4'b0001) begin
            failures++;
            $display("FAIL areset_ptr: got %b expected 0001", bus.gnt);
        end
        bus.req = 4'b1000;
        #1;
        checks++;
        if (bus.gnt !== 4'b1000) begin
            failures++;
            $display("FAIL areset_gnt3: got %b expected 1000", bus.gnt);
        end
        @(negedge clk);
        bus.req = '0;
        bus.pop = 1'b1;
        repeat (3) @(negedge clk);
        bus.pop = 1'b0;
    endtask

`ifdef FIFO_PUSH_ARB_STATS_EN
    task automatic test_stats;
        @(negedge clk);
        bus.req = 4'b0010;
        bus.pop = 1'b1;
        repeat (10) @(negedge clk);
        bus.req = '0;
        #1;
        checks++;
        if (grant_cnt[16 +: 16] !== 16'd10) begin
            failures++;
            $display("FAIL stats_count: got %0d expected 10", grant_cnt[16 +: 16]);
        end
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        #1;
        checks++;
        if (grant_cnt[16 +: 16] !== 16'd0) begin
            failures++;
            $display("FAIL stats_clear: got %0d expected 0", grant_cnt[16 +: 16]);
        end
        bus.req = 4'b0010;
        repeat (65535) @(negedge clk);
        #1;
        checks++;
        if (grant_cnt[16 +: 16] !== 16'hFFFF) begin
            failures++;
            $display("FAIL stats_reach_max: got %h expected ffff", grant_cnt[16 +: 16]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (grant_cnt[16 +: 16] !== 16'hFFFF) begin
            failures++;
            $display("FAIL stats_saturate: got %h expected ffff", grant_cnt[16 +: 16]);
        end
        bus.req = '0;
        bus.pop = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_round_robin();
        test_fill_full();
        test_simul_push_pop();
        test_async_reset();
`ifdef FIFO_PUSH_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
